// File: rtl/aclk_pkg.sv
// Shared alarm-clock definitions: controller state encoding, idle key code
// and default entry timeout.
package aclk_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SHOW_ALARM = 3'd4
    } aclk_state_e;

    localparam logic [3:0] NOKEY = 4'hA;
    localparam int TIMEOUT_SEC_DEFAULT = 10;

endpackage

// File: rtl/aclk_timeout_counter.sv
// Counts one_second ticks of keypad inactivity and flags the tick that
// completes the timeout window.
module aclk_timeout_counter #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_SEC - 1);
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT_SEC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturates instead of wrapping so a stale count never re-fires.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = enable && (count_q == LAST);

endmodule

// File: rtl/aclk_controller.sv
// Alarm clock sequencer: keypad entry, alarm display and load pulses
// for the alarm and time registers, with an idle timeout.
module aclk_controller #(
    parameter int TIMEOUT_SEC = aclk_pkg::TIMEOUT_SEC_DEFAULT,
    parameter logic [3:0] NOKEY = aclk_pkg::NOKEY
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_alarm,
    output logic       show_new_time,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count
);

    import aclk_pkg::*;

    aclk_state_e state_q, state_d;
    logic show_alarm_q, show_alarm_d;
    logic show_new_time_q, show_new_time_d;
    logic shift_q, shift_d;
    logic load_new_a_q, load_new_a_d;
    logic load_new_c_q, load_new_c_d;

    logic key_idle;
    logic in_entry;
    logic tmo_clear;
    logic tmo_enable;
    logic timeout;

    assign key_idle = (key == NOKEY);
    assign in_entry = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    assign tmo_enable = one_second && in_entry;
    assign tmo_clear = !in_entry || (state_d == KEY_STORED);

    aclk_timeout_counter #(
        .TIMEOUT_SEC(TIMEOUT_SEC)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        load_new_a_d = 1'b0;
        load_new_c_d = 1'b0;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button) begin
                    state_d = SHOW_ALARM;
                end else if (!key_idle) begin
                    state_d = KEY_STORED;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) begin
                    state_d = SHOW_TIME;
                end
            end
            KEY_STORED: state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (key_idle) begin
                    state_d = KEY_ENTRY;
                end else if (timeout) begin
                    state_d = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    state_d = SHOW_TIME;
                    load_new_a_d = 1'b1;
                end else if (time_button) begin
                    state_d = SHOW_TIME;
                    load_new_c_d = 1'b1;
                end else if (!key_idle) begin
                    state_d = KEY_STORED;
                end else if (timeout) begin
                    state_d = SHOW_TIME;
                end
            end
            default: state_d = SHOW_TIME;
        endcase
        show_alarm_d = (state_d == SHOW_ALARM);
        show_new_time_d = (state_d == KEY_STORED) ||
                          (state_d == KEY_WAITED) ||
                          (state_d == KEY_ENTRY);
        shift_d = (state_d == KEY_STORED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SHOW_TIME;
            show_alarm_q <= 1'b0;
            show_new_time_q <= 1'b0;
            shift_q <= 1'b0;
            load_new_a_q <= 1'b0;
            load_new_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            show_alarm_q <= show_alarm_d;
            show_new_time_q <= show_new_time_d;
            shift_q <= shift_d;
            load_new_a_q <= load_new_a_d;
            load_new_c_q <= load_new_c_d;
        end
    end

    assign show_alarm = show_alarm_q;
    assign show_new_time = show_new_time_q;
    assign shift = shift_q;
    assign load_new_a = load_new_a_q;
    assign load_new_c = load_new_c_q;
    assign reset_count = load_new_c_q;

endmodule

// File: tb/tb_aclk_controller.sv
// Self-checking bench for aclk_controller: vector table, corner-case
// sequences and a randomized run against an event-level reference model.
module tb_aclk_controller;

    import aclk_pkg::*;

    localparam int TSEC = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic one_second = 1'b0;
    logic [3:0] key = NOKEY;
    logic alarm_button = 1'b0;
    logic time_button = 1'b0;
    logic show_alarm, show_new_time, shift;
    logic load_new_a, load_new_c, reset_count;
    logic [5:0] outs;

    int n_checks = 0;
    int n_fail = 0;

    aclk_controller #(
        .TIMEOUT_SEC(TSEC),
        .NOKEY(NOKEY)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .key          (key),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .show_alarm   (show_alarm),
        .show_new_time(show_new_time),
        .shift        (shift),
        .load_new_a   (load_new_a),
        .load_new_c   (load_new_c),
        .reset_count  (reset_count)
    );

    always #5 clock = ~clock;

    // {show_alarm, show_new_time, shift, load_new_a, load_new_c, reset_count}
    assign outs = {show_alarm, show_new_time, shift,
                   load_new_a, load_new_c, reset_count};

    typedef struct {
        logic [3:0] k;
        logic       a;
        logic       t;
        logic       s;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[12];

    // Reference model: what the user is doing, not how the FSM encodes it.
    bit m_alarm, m_entry, m_fresh, m_held;
    int m_idle;
    logic [5:0] m_exp;

    task automatic model_reset();
        m_alarm = 0; m_entry = 0; m_fresh = 0; m_held = 0; m_idle = 0;
    endtask

    task automatic model(input logic [3:0] k, input bit a, input bit t,
                         input bit s);
        bit la, lc, expire, counting;
        la = 0; lc = 0;
        counting = m_entry && !m_fresh;
        expire = s && (m_idle == TSEC - 1);
        if (m_alarm) begin
            if (!a) m_alarm = 0;
        end else if (!m_entry) begin
            if (a) m_alarm = 1;
            else if (k != NOKEY) begin
                m_entry = 1; m_fresh = 1; m_held = 1;
            end
        end else if (m_fresh) begin
            m_fresh = 0;
        end else if (m_held) begin
            if (k == NOKEY) m_held = 0;
            else if (expire) begin m_entry = 0; m_held = 0; end
        end else begin
            if (a) begin m_entry = 0; la = 1; end
            else if (t) begin m_entry = 0; lc = 1; end
            else if (k != NOKEY) begin m_fresh = 1; m_held = 1; end
            else if (expire) m_entry = 0;
        end
        if (!m_entry || m_fresh) m_idle = 0;
        else if (counting && s) m_idle = (m_idle < TSEC) ? m_idle + 1 : TSEC;
        m_exp = {m_alarm, m_entry, m_fresh, la, lc, lc};
    endtask

    task automatic step(input logic [3:0] k, input logic a, input logic t,
                        input logic s);
        key = k; alarm_button = a; time_button = t; one_second = s;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, outs, exp);
        end
    endtask

    task automatic go(input logic [3:0] k, input logic a, input logic t,
                      input logic s, input string name,
                      input logic [5:0] exp);
        step(k, a, t, s);
        check(name, exp);
    endtask

    task automatic enter(input logic [3:0] k, input string name);
        go(k, 0, 0, 0, {name, "_store"}, 6'b011000);
        go(NOKEY, 0, 0, 0, {name, "_wait"}, 6'b010000);
        go(NOKEY, 0, 0, 0, {name, "_entry"}, 6'b010000);
    endtask

    initial begin
        logic [3:0] cur_k;
        int shifts;

        tbl[0]  = '{4'h4, 1'b0, 1'b0, 1'b0, 6'b011000, "t2_key4"};
        tbl[1]  = '{4'h4, 1'b0, 1'b0, 1'b0, 6'b010000, "t2_key4_held"};
        tbl[2]  = '{NOKEY, 1'b0, 1'b0, 1'b0, 6'b010000, "t2_release4"};
        tbl[3]  = '{4'h7, 1'b0, 1'b0, 1'b0, 6'b011000, "t2_key7"};
        tbl[4]  = '{NOKEY, 1'b0, 1'b0, 1'b0, 6'b010000, "t2_release7"};
        tbl[5]  = '{NOKEY, 1'b0, 1'b0, 1'b0, 6'b010000, "t2_entry"};
        tbl[6]  = '{NOKEY, 1'b0, 1'b1, 1'b0, 6'b000011, "t2_load_c"};
        tbl[7]  = '{NOKEY, 1'b0, 1'b0, 1'b0, 6'b000000, "t2_after"};
        tbl[8]  = '{4'h3, 1'b1, 1'b0, 1'b0, 6'b100000, "t5_alarm_on"};
        tbl[9]  = '{4'h5, 1'b1, 1'b0, 1'b1, 6'b100000, "t5_key_ignored"};
        tbl[10] = '{4'h5, 1'b0, 1'b0, 1'b0, 6'b000000, "t5_alarm_off"};
        tbl[11] = '{NOKEY, 1'b0, 1'b0, 1'b0, 6'b000000, "t5_idle"};

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 6'b000000);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            go(tbl[i].k, tbl[i].a, tbl[i].t, tbl[i].s, tbl[i].name, tbl[i].exp);
        end

        // Held key: one shift, buttons ignored until release.
        go(4'h3, 0, 0, 0, "t3_press", 6'b011000);
        shifts = 0;
        for (int i = 0; i < 49; i++) begin
            step(4'h3, 0, (i >= 20 && i < 30), 0);
            if (shift) shifts++;
            check("t3_held", 6'b010000);
        end
        n_checks++;
        if (shifts != 0) begin
            n_fail++;
            $display("FAIL t3_extra_shifts: got %0d expected 0", shifts);
        end
        go(NOKEY, 0, 0, 0, "t3_release", 6'b010000);
        go(NOKEY, 0, 1, 0, "t3_load_c", 6'b000011);
        go(NOKEY, 0, 0, 0, "t3_after", 6'b000000);

        // Idle timeout on the 10th tick, no load.
        enter(4'h5, "t4a");
        for (int i = 1; i <= TSEC; i++) begin
            go(NOKEY, 0, 0, 1, "t4_tick", (i < TSEC) ? 6'b010000 : 6'b000000);
            if (i < TSEC) go(NOKEY, 0, 0, 0, "t4_gap", 6'b010000);
        end
        go(NOKEY, 0, 0, 0, "t4_no_load", 6'b000000);

        // Key coinciding with the expiring tick wins and restarts the count.
        enter(4'h5, "t4b");
        for (int i = 1; i < TSEC; i++) go(NOKEY, 0, 0, 1, "t4b_tick", 6'b010000);
        go(4'h6, 0, 0, 1, "t4_key_beats_timeout", 6'b011000);
        go(NOKEY, 0, 0, 0, "t4c_wait", 6'b010000);
        go(NOKEY, 0, 0, 0, "t4c_entry", 6'b010000);
        for (int i = 1; i < TSEC; i++) go(NOKEY, 0, 0, 1, "t4_restarted", 6'b010000);
        go(NOKEY, 0, 0, 1, "t4_restart_expire", 6'b000000);

        // Both buttons together: alarm wins.
        enter(4'h1, "t6");
        go(NOKEY, 1, 1, 0, "t6_both_buttons", 6'b000100);
        go(NOKEY, 0, 0, 0, "t6_after", 6'b000000);

        // Reset mid entry: immediate clear, no load afterwards.
        enter(4'h2, "t1");
        reset = 1'b1;
        time_button = 1'b1;
        #1;
        check("t1_async_reset", 6'b000000);
        @(posedge clock);
        #1;
        check("t1_in_reset", 6'b000000);
        reset = 1'b0;
        go(NOKEY, 0, 1, 0, "t1_no_load", 6'b000000);
        go(NOKEY, 0, 0, 0, "t1_idle", 6'b000000);

        // Randomized run against the model.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        cur_k = NOKEY;
        for (int i = 0; i < 4000; i++) begin
            bit a, t, s;
            int pk;
            pk = ((i / 400) % 2 == 1) ? 50 : 6;
            if ($urandom % 4 == 0) begin
                cur_k = ($urandom % 100 < pk) ? 4'($urandom % 16) : NOKEY;
            end
            a = ($urandom % 12 == 0);
            t = ($urandom % 12 == 0);
            s = ($urandom % 4 == 0);
            model(cur_k, a, t, s);
            step(cur_k, a, t, s);
            check("random", m_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
